// File: rtl/sr_telemetry_sequencer_if.sv
// Output stream interface for sr_telemetry_sequencer.
//   m_valid : beat valid (master -> slave)
//   m_ready : downstream ready (slave -> master)
//   m_data  : signed converted value
//   m_field : field index 0..14
//   m_last  : high on field 14
//   m_seq   : sample index of the burst being streamed
interface sr_telemetry_sequencer_if;
  logic               m_valid;
  logic               m_ready;
  logic signed [31:0] m_data;
  logic [3:0]         m_field;
  logic               m_last;
  logic [31:0]        m_seq;

  modport master (output m_valid, m_data, m_field, m_last, m_seq, input m_ready);
  modport slave  (input m_valid, m_data, m_field, m_last, m_seq, output m_ready);
endinterface

// File: rtl/sr_telemetry_sequencer.sv
// Periodic telemetry readout of the 5-harmonic SR bank.
// Divides the 4 kHz update strobe down to a sample tick, snapshots the 15
// state values, converts them through one shared signed multiplier and
// streams them as a 15-beat valid/ready burst.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clk_en          : 4 kHz update strobe (one cycle)
//   enable          : sampling enable, clears the divisor counter when low
//   sample_div      : strobes per sample tick (0 behaves as 1)
//   *_packed        : 5 lanes of WIDTH bits, lane i = harmonic i
//   m               : output stream (master modport)
//   busy            : burst in progress
//   overrun_cnt     : saturating count of ticks dropped while busy
module sr_telemetry_sequencer #(
  parameter int WIDTH       = 18,
  parameter int FRAC        = 14,
  parameter int FREQ_MULT   = 4074767,
  parameter int FREQ_SHIFT  = 20,
  parameter int AMP_SCALE_0 = 16384,
  parameter int AMP_SCALE_1 = 13926,
  parameter int AMP_SCALE_2 = 5571,
  parameter int AMP_SCALE_3 = 2458,
  parameter int AMP_SCALE_4 = 983
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 enable,
  input  logic [15:0]          sample_div,
  input  logic [5*WIDTH-1:0]   omega_dt_packed,
  input  logic [5*WIDTH-1:0]   amp_packed,
  input  logic [5*WIDTH-1:0]   q_scaled_packed,
  sr_telemetry_sequencer_if.master m,
  output logic                 busy,
  output logic [15:0]          overrun_cnt
);

  localparam int PW = WIDTH + 24;

  typedef enum logic [1:0] {IDLE, LOAD, MUL2, PRESENT} state_t;

  state_t state_q, state_d;

  logic [15:0]              div_q;
  logic [3:0]               field_q;
  logic signed [WIDTH-1:0]  p_q;
  logic signed [31:0]       data_q;
  logic [3:0]               mfield_q;
  logic                     last_q;
  logic [31:0]              seq_q;
  logic [15:0]              ovr_q;
  logic signed [WIDTH-1:0]  om_q  [5];
  logic signed [WIDTH-1:0]  amp_q [5];
  logic signed [WIDTH-1:0]  qv_q  [5];

  logic [15:0] div_max;
  logic        tick, start, accept;
  logic        is_amp, is_q;
  logic [2:0]  h;
  logic signed [WIDTH-1:0] mul_a;
  logic signed [23:0]      mul_b;
  logic signed [PW-1:0]    prod, prod_f, prod_q;

  assign div_max = (sample_div == 16'd0) ? 16'd0 : sample_div - 16'd1;
  assign tick    = enable && clk_en && (div_q == div_max);
  assign is_amp  = (field_q >= 4'd5) && (field_q <= 4'd9);
  assign is_q    = (field_q >= 4'd10);

  // harmonic lane addressed by the current field
  always_comb begin
    h = field_q[2:0];
    if (is_q)        h = 3'(field_q - 4'd10);
    else if (is_amp) h = 3'(field_q - 4'd5);
  end

  // Shared multiplier: second amplitude pass reuses it with p_q x 100.
  always_comb begin
    mul_a = om_q[h];
    mul_b = 24'(FREQ_MULT);
    if (state_q == MUL2) begin
      mul_a = p_q;
      mul_b = 24'sd100;
    end else if (is_amp) begin
      mul_a = amp_q[h];
      case (h)
        3'd0:    mul_b = 24'(AMP_SCALE_0);
        3'd1:    mul_b = 24'(AMP_SCALE_1);
        3'd2:    mul_b = 24'(AMP_SCALE_2);
        3'd3:    mul_b = 24'(AMP_SCALE_3);
        default: mul_b = 24'(AMP_SCALE_4);
      endcase
    end
  end

  assign prod   = mul_a * mul_b;
  assign prod_f = prod >>> FREQ_SHIFT;
  assign prod_q = prod >>> FRAC;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = is_amp ? MUL2 : PRESENT;
      MUL2:    state_d = PRESENT;
      PRESENT: if (accept) state_d = (field_q == 4'd14) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    m.m_valid = (state_q == PRESENT);
    busy      = (state_q != IDLE);
    accept    = (state_q == PRESENT) && m.m_ready;
    start     = tick && (state_q == IDLE);
  end

  assign m.m_data     = data_q;
  assign m.m_field    = mfield_q;
  assign m.m_last     = last_q;
  assign m.m_seq      = seq_q;
  assign overrun_cnt  = ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      field_q  <= '0;
      p_q      <= '0;
      data_q   <= '0;
      mfield_q <= '0;
      last_q   <= 1'b0;
      seq_q    <= '0;
      ovr_q    <= '0;
      for (int i = 0; i < 5; i++) begin
        om_q[i]  <= '0;
        amp_q[i] <= '0;
        qv_q[i]  <= '0;
      end
    end else begin
      // divisor keeps running during a burst; only enable clears it
      if (!enable)     div_q <= '0;
      else if (clk_en) div_q <= (div_q == div_max) ? 16'd0 : div_q + 16'd1;

      if (start) begin
        field_q <= '0;
        for (int i = 0; i < 5; i++) begin
          om_q[i]  <= omega_dt_packed[i*WIDTH +: WIDTH];
          amp_q[i] <= amp_packed[i*WIDTH +: WIDTH];
          qv_q[i]  <= q_scaled_packed[i*WIDTH +: WIDTH];
        end
      end

      if (tick && busy && (ovr_q != 16'hFFFF)) ovr_q <= ovr_q + 16'd1;

      if (state_q == LOAD) begin
        if (is_amp) begin
          p_q <= prod_q[WIDTH-1:0];
        end else begin
          data_q   <= is_q ? {{(32-WIDTH){qv_q[h][WIDTH-1]}}, qv_q[h]} : prod_f[31:0];
          mfield_q <= field_q;
          last_q   <= (field_q == 4'd14);
        end
      end

      if (state_q == MUL2) begin
        data_q   <= prod_q[31:0];
        mfield_q <= field_q;
        last_q   <= (field_q == 4'd14);
      end

      if (accept) begin
        if (field_q == 4'd14) seq_q   <= seq_q + 32'd1;
        else                  field_q <= field_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sr_telemetry_sequencer.sv
module tb_sr_telemetry_sequencer;
  localparam int W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic enable = 1'b0;
  logic [15:0] sample_div = '0;
  logic [5*W-1:0] om = '0, amp = '0, qv = '0;
  logic busy;
  logic [15:0] overrun_cnt;

  sr_telemetry_sequencer_if bus();

  sr_telemetry_sequencer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .enable(enable), .sample_div(sample_div),
    .omega_dt_packed(om), .amp_packed(amp), .q_scaled_packed(qv),
    .m(bus.master), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] d;
    logic [3:0]         f;
    logic               l;
    logic [31:0]        s;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int failures = 0;

  localparam int OMV  [5] = '{199, 354, 514, 643, 823};
  localparam int FRQ  [5] = '{773, 1375, 1997, 2498, 3198};
  localparam int AMPX [5] = '{100, 84, 34, 15, 5};
  localparam int QX   [5] = '{20, 18, 16, 14, 12};

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_inputs(input int o0);
    for (int i = 0; i < 5; i++) begin
      om[i*W +: W]  = 18'((i == 0) ? o0 : OMV[i]);
      amp[i*W +: W] = 18'(16384);
      qv[i*W +: W]  = 18'(QX[i]);
    end
  endtask

  task automatic push_burst(input int seq, input int f0, input int nbeats);
    beat_t e;
    for (int i = 0; i < nbeats; i++) begin
      e.f = 4'(i);
      e.l = (i == 14);
      e.s = 32'(seq);
      if (i < 5)       e.d = (i == 0) ? f0 : FRQ[i];
      else if (i < 10) e.d = AMPX[i-5];
      else             e.d = QX[i-10];
      exp_q.push_back(e);
    end
  endtask

  // one-cycle clk_en; returns 1 time unit after the edge that samples it
  task automatic strobe();
    @(posedge clk); #1 clk_en = 1'b1;
    @(posedge clk); #1 clk_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, (n < 3000) ? 1 : 0, 1);
  endtask

  // monitor / scoreboard
  logic               hold_v = 1'b0;
  logic signed [31:0] hold_d;
  logic [3:0]         hold_f;

  always @(negedge clk) begin
    beat_t e;
    if (bus.m_valid && hold_v) begin
      chk("hold_data", bus.m_data, hold_d);
      chk("hold_field", bus.m_field, hold_f);
    end
    hold_v = bus.m_valid && !bus.m_ready;
    hold_d = bus.m_data;
    hold_f = bus.m_field;
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat field=%0d data=%0d required=none", bus.m_field, bus.m_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_field", bus.m_field, e.f);
        chk("beat_data", bus.m_data, e.d);
        chk("beat_last", bus.m_last, e.l);
        chk("beat_seq", bus.m_seq, e.s);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_seq", bus.m_seq, 0);
    rst = 1'b0;

    // freq/amp/Q burst with ready held high, latency measured from E0
    set_inputs(199);
    sample_div = 16'd4;
    enable = 1'b1;
    bus.m_ready = 1'b1;
    push_burst(0, 773, 15);
    for (int k = 0; k < 3; k++) begin
      strobe();
      repeat (3) @(posedge clk);
    end
    #1 chk("no_early_tick", busy, 0);
    strobe();
    chk("busy_after_tick", busy, 1);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("burst_edges", n, 35);
    wait_idle("drain_s1");
    chk("seq_after_s1", bus.m_seq, 1);

    // random backpressure, inputs disturbed after the snapshot
    push_burst(1, 773, 15);
    for (int k = 0; k < 4; k++) begin
      strobe();
      if (k < 3) repeat (3) @(posedge clk);
    end
    om = {5*W{1'b1}};
    amp = '0;
    qv = {5{18'(777)}};
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1 bus.m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    bus.m_ready = 1'b1;
    set_inputs(199);
    wait_idle("drain_s3");
    chk("seq_after_s3", bus.m_seq, 2);

    // overruns while stalled
    sample_div = 16'd1;
    bus.m_ready = 1'b0;
    push_burst(2, 773, 15);
    for (int k = 0; k < 20; k++) begin
      strobe();
      repeat (8) @(posedge clk);
    end
    #1;
    chk("overrun_19", overrun_cnt, 19);
    chk("busy_stalled", busy, 1);
    bus.m_ready = 1'b1;
    wait_idle("drain_s4");
    repeat (20) @(posedge clk);
    #1;
    chk("seq_after_s4", bus.m_seq, 3);
    chk("overrun_hold", overrun_cnt, 19);

    // negative omega, sample_div 0 vs 1
    sample_div = 16'd0;
    set_inputs(-199);
    push_burst(3, -774, 15);
    strobe();
    wait_idle("drain_s5a");
    sample_div = 16'd1;
    push_burst(4, -774, 15);
    strobe();
    wait_idle("drain_s5b");
    chk("seq_after_s5", bus.m_seq, 5);

    // reset while beat 7 is presented
    set_inputs(199);
    push_burst(5, 773, 7);
    strobe();
    n = 0;
    while (!(bus.m_valid && bus.m_field == 4'd7) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_beat7", (n < 200) ? 1 : 0, 1);
    bus.m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.m_valid, 0);
    chk("mid_rst_data", bus.m_data, 0);
    chk("mid_rst_field", bus.m_field, 0);
    chk("mid_rst_last", bus.m_last, 0);
    chk("mid_rst_seq", bus.m_seq, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun_cnt, 0);
    chk("beats_before_rst", exp_q.size(), 0);
    @(posedge clk); #1 rst = 1'b0;
    bus.m_ready = 1'b1;
    push_burst(0, 773, 15);
    strobe();
    wait_idle("drain_s6");
    chk("seq_after_s6", bus.m_seq, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sr_telemetry_sequencer.md
Name: sr_telemetry_sequencer

Overview:
Schedules periodic readout of the 5-harmonic SR bank state: omega_dt, Hopf amplitude and scaled Q-factor for harmonics 0–4, 15 fields per sample.
Counts 4 kHz update strobes, snapshots all 15 values on each sample tick, and converts them through one shared multiplier.
Streams the results as a 15-beat valid/ready burst to the logging/UART layer.
Replaces per-harmonic conversion multipliers with a single time-multiplexed one.

Parameters:
WIDTH, 18, bit width of each packed input lane
FRAC, 14, fractional bits of the Q-format inputs
FREQ_MULT, 4074767, Hz×100 conversion constant (3.886 × 2^20)
FREQ_SHIFT, 20, right shift applied after the FREQ_MULT product
AMP_SCALE_0..AMP_SCALE_4, 16384/13926/5571/2458/983, per-harmonic Q14 amplitude scale factors

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
clk_en  in  1  4 kHz update strobe, one cycle wide
enable  in  1  sampling enable
sample_div  in  16  number of strobes per sample; 0 is treated as 1
omega_dt_packed  in  5*WIDTH  signed, lane i = harmonic i
amp_packed  in  5*WIDTH  signed Q14 amplitudes
q_scaled_packed  in  5*WIDTH  signed Q values
m_valid  out  1  output beat valid
m_ready  in  1  downstream ready
m_data  out  32  signed converted value
m_field  out  4  field index 0–14
m_last  out  1  high on field 14
m_seq  out  32  sample index of the current burst
busy  out  1  burst in progress
overrun_cnt  out  16  count of dropped ticks, saturating

Behaviour:
- Reset (async): all outputs 0, state IDLE, divisor counter 0, shadow registers 0.
- Divisor counter:
  - Increments on each clk_en while enable=1.
  - Cleared while enable=0.
  - On a clk_en where counter == max(sample_div,1)−1, the counter wraps to 0 and a tick is generated.
  - The counter keeps running while busy.
- Tick handling:
  - Tick while IDLE (edge E0): all 15 inputs are loaded into shadow registers, field=0, state→LOAD, busy=1.
  - Tick while busy: tick is dropped and overrun_cnt increments, saturating at 0xFFFF; it does not wrap.
- Field order and conversion (arithmetic is signed throughout, with the full 42-bit product):
  - Fields 0–4 (freq, Hz×100): (omega_i × FREQ_MULT) >>> FREQ_SHIFT. Takes 1 multiply cycle.
  - Fields 5–9 (amplitude, 0–100): first p = (amp_i × AMP_SCALE_i) >>> FRAC, then (p × 100) >>> FRAC. Takes 2 multiply cycles on the same multiplier.
  - Fields 10–14 (Q): q_i sign-extended to 32 bits, no multiply.
- States:
  - IDLE.
  - LOAD: issue the first multiply, or the Q pass-through.
  - MUL2: amplitude fields only.
  - PRESENT.
- Transitions:
  - LOAD→PRESENT for freq and Q fields.
  - LOAD→MUL2→PRESENT for amplitude fields.
  - m_data, m_field and m_last are registered on entry to PRESENT.
- Handshake:
  - m_valid=1 only in PRESENT.
  - m_data, m_field and m_last are held stable until m_valid && m_ready.
  - On accept: field<14 → field+1, state→LOAD; field==14 → IDLE, busy=0, m_seq+1 on the same edge.
- Latency:
  - First m_valid is asserted after E1, the edge following E0.
  - With m_ready held at 1, the final accept occurs at E35 (freq 5×2 + amp 5×3 + Q 5×2 edges).
- Shadow registers isolate the burst from input changes after E0.
- enable deasserted mid-burst: the burst completes; no new ticks are generated.
- clk_en and accept on the same edge: both are processed independently.
- Reset mid-burst: the burst is aborted immediately; m_valid=0, m_seq=0, overrun_cnt=0.

Test Plan:
1. sample_div=4, enable=1, omega lanes 199/354/514/643/823, m_ready=1 → after the 4th clk_en, 15 beats:
   - Fields 0–4 = 773/1375/1997/2498/3198.
   - m_last on beat 15 only, m_seq=0.
   - busy falls 35 edges after E0.
2. amp lanes all 16384, Q lanes 20/18/16/14/12 → fields 5–9 = 100/84/34/15/5; fields 10–14 = 20/18/16/14/12.
3. m_ready toggled pseudo-randomly and inputs changed after E0 → identical data to scenario 1; m_data and m_field stable while m_valid=1 && m_ready=0.
4. sample_div=1, clk_en every 10 cycles, m_ready=0 for 200 cycles → overrun_cnt increments once per dropped tick; after release, exactly one burst completes; m_seq advances by 1.
5. Negative omega_dt=−199 → field 0 = −774 (arithmetic shift floor); sample_div=0 behaves identically to sample_div=1.
6. Assert rst while beat 7 is presented → all outputs 0 immediately (asynchronous); after release, the next tick starts a fresh burst with m_seq=0.
